irig_encoder: RTL and testbench
===============================

IRIG_ENCODER -- requirements
Module: irig_encoder

Interface
REQ-001 Parameter CLKS_PER_MS, default 10000: clk cycles per 1 ms, legal range 2..65535.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to transmit one frame from the current ts_* inputs.
REQ-005 ts_second  input  6  seconds, binary, 0..59.
REQ-006 ts_minute  input  6  minutes, binary, 0..59.
REQ-007 ts_hour  input  5  hours, binary, 0..23.
REQ-008 ts_day  input  9  day of year, binary, 1..366.
REQ-009 ts_year  input  7  year within century, binary, 0..99.
REQ-010 ts_sec_day  input  17  straight-binary seconds of day, 0..86399.
REQ-011 irig_out  output  1  IRIG-B pulse-width-coded serial output.
REQ-012 busy  output  1  high while a frame is in progress.
REQ-013 bit_idx  output  7  index (0..99) of the symbol currently transmitted.
REQ-014 frame_done  output  1  one-cycle pulse when symbol 99 completes.

Function
REQ-015 States: IDLE and SEND only; IDLE->SEND on start, SEND->IDLE at end of symbol 99 unless start is high in that cycle.
REQ-016 In IDLE, start high for one cycle latches all ts_* into internal registers and enters SEND; irig_out goes high on the next rising edge.
REQ-017 start while in SEND is ignored, except in the final cycle of symbol 99, where it latches new ts_* and starts symbol 0 with no gap.
REQ-018 Each symbol lasts exactly 10*CLKS_PER_MS cycles: irig_out high for the first 2 ms (bit 0), 5 ms (bit 1) or 8 ms (position marker P), low for the remainder.
REQ-019 Markers P at symbols 0, 9, 19, 29, 39, 49, 59, 69, 79, 89, 99.
REQ-020 Seconds: units weights 1,2,4,8 at symbols 1-4; tens weights 10,20,40 at 6-8.
REQ-021 Minutes: units at 10-13; tens 10,20,40 at 15-17.
REQ-022 Hours: units at 20-23; tens 10,20 at 25-26.
REQ-023 Day: units at 30-33; tens 10,20,40,80 at 35-38; hundreds 100,200 at 40-41.
REQ-024 Year: units at 50-53; tens 10,20,40,80 at 55-58.
REQ-025 ts_sec_day LSB-first: bits 0-8 at symbols 80-88, bits 9-16 at 90-97.
REQ-026 All other non-marker symbols (5, 14, 18, 24, 27-28, 34, 42-48, 54, 60-68, 70-78, 98) are bit 0.
REQ-027 BCD digits derived from latched binary values as units = v mod 10, tens = (v/10) mod 10, hundreds = v/100; digits truncated to their field width with no range check.
REQ-028 Input changes after latching do not affect the frame in progress.
REQ-029 bit_idx is 0 in IDLE and equals the current symbol index in SEND; it increments on the first cycle of each new symbol.
REQ-030 frame_done pulses high in the cycle after the last cycle of symbol 99, whether or not a back-to-back frame starts.
REQ-031 busy is high from the cycle after start is accepted through the last cycle of symbol 99, and stays high across back-to-back frames.

Reset
REQ-032 rst high at a clock edge forces IDLE; irig_out=0, busy=0, bit_idx=0, frame_done=0; all counters and latched fields are cleared.
REQ-033 rst mid-frame aborts the frame with no further pulses; a start in the same cycle as rst is ignored.

Verification (CLKS_PER_MS=4, symbol = 40 cycles)
REQ-034 rst, then start with sec=0, min=0, hr=0, day=1, yr=0, sec_day=0 -> symbol 0 high for 32 cycles; symbol 30 high for 20 cycles; all other data symbols high for 8 cycles; frame_done at cycle 4000.
REQ-035 sec=59, min=59, hr=23, day=366, yr=99, sec_day=86399 -> decoded output pulse widths reproduce every field exactly, including bits 40-41 = 1,1 (day hundreds = 3).
REQ-036 start repeated during symbol 50 -> ignored; ts_* changed mid-frame -> no effect on the current frame.
REQ-037 start held in the last cycle of symbol 99 -> new symbol 0 begins the next cycle; busy stays high; frame_done pulses once.
REQ-038 rst asserted during symbol 37 -> next cycle irig_out=0, busy=0, bit_idx=0; a later start produces a full, correct frame.

Source files
------------

// File: rtl/irig_encoder_if.sv
// Signal bundle between an IRIG-B frame requester and the encoder.
// The master side supplies the timestamp and start; the slave side returns the serial output and status.
interface irig_encoder_if;
    logic        start;
    logic [5:0]  ts_second;
    logic [5:0]  ts_minute;
    logic [4:0]  ts_hour;
    logic [8:0]  ts_day;
    logic [6:0]  ts_year;
    logic [16:0] ts_sec_day;
    logic        irig_out;
    logic        busy;
    logic [6:0]  bit_idx;
    logic        frame_done;

    modport master (
        output start, ts_second, ts_minute, ts_hour, ts_day, ts_year, ts_sec_day,
        input  irig_out, busy, bit_idx, frame_done
    );

    modport slave (
        input  start, ts_second, ts_minute, ts_hour, ts_day, ts_year, ts_sec_day,
        output irig_out, busy, bit_idx, frame_done
    );
endinterface

// File: rtl/irig_encoder.sv
// IRIG-B pulse-width-coded frame encoder: 100 symbols of 10 ms each, built from a timestamp
// latched when start is accepted, with support for seamless back-to-back frames.
module irig_encoder #(
    parameter int CLKS_PER_MS = 10000
) (
    input logic           clk,
    input logic           rst,
    irig_encoder_if.slave bus
);
    localparam logic [19:0] SYM_LEN  = 20'(10 * CLKS_PER_MS);
    localparam logic [19:0] P_LEN    = 20'(8 * CLKS_PER_MS);
    localparam logic [19:0] ONE_LEN  = 20'(5 * CLKS_PER_MS);
    localparam logic [19:0] ZERO_LEN = 20'(2 * CLKS_PER_MS);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state;
    logic [19:0] cnt;
    logic [6:0]  sym;
    logic        irig_r;
    logic        busy_r;
    logic        done_r;

    logic [5:0]  sec_l;
    logic [5:0]  min_l;
    logic [4:0]  hr_l;
    logic [8:0]  day_l;
    logic [6:0]  yr_l;
    logic [16:0] sd_l;

    logic        last_cycle;
    logic        accept;
    logic        is_marker;
    logic [99:0] data_bits;
    logic [19:0] high_len;

    assign last_cycle = (state == SEND) && (cnt == SYM_LEN - 20'd1) && (sym == 7'd99);
    assign accept     = bus.start && ((state == IDLE) || last_cycle);

    // BCD digits are taken from the latched binary fields and simply truncated to their slot width.
    always_comb begin
        data_bits        = '0;
        data_bits[4:1]   = 4'(sec_l % 6'd10);
        data_bits[8:6]   = 3'((sec_l / 6'd10) % 6'd10);
        data_bits[13:10] = 4'(min_l % 6'd10);
        data_bits[17:15] = 3'((min_l / 6'd10) % 6'd10);
        data_bits[23:20] = 4'(hr_l % 5'd10);
        data_bits[26:25] = 2'((hr_l / 5'd10) % 5'd10);
        data_bits[33:30] = 4'(day_l % 9'd10);
        data_bits[38:35] = 4'((day_l / 9'd10) % 9'd10);
        data_bits[41:40] = 2'(day_l / 9'd100);
        data_bits[53:50] = 4'(yr_l % 7'd10);
        data_bits[58:55] = 4'((yr_l / 7'd10) % 7'd10);
        data_bits[88:80] = sd_l[8:0];
        data_bits[97:90] = sd_l[16:9];
    end

    always_comb begin
        is_marker = sym inside {7'd0, 7'd9, 7'd19, 7'd29, 7'd39, 7'd49,
                                7'd59, 7'd69, 7'd79, 7'd89, 7'd99};
        if (is_marker)
            high_len = P_LEN;
        else if (data_bits[sym])
            high_len = ONE_LEN;
        else
            high_len = ZERO_LEN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_l <= '0;
            min_l <= '0;
            hr_l  <= '0;
            day_l <= '0;
            yr_l  <= '0;
            sd_l  <= '0;
        end else if (accept) begin
            sec_l <= bus.ts_second;
            min_l <= bus.ts_minute;
            hr_l  <= bus.ts_hour;
            day_l <= bus.ts_day;
            yr_l  <= bus.ts_year;
            sd_l  <= bus.ts_sec_day;
        end
    end

    // Every symbol starts high, so the output is raised on each symbol boundary and
    // dropped once the in-symbol count reaches the width for the current symbol.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sym    <= '0;
            irig_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= SEND;
                        cnt    <= '0;
                        sym    <= '0;
                        irig_r <= 1'b1;
                        busy_r <= 1'b1;
                    end
                end
                SEND: begin
                    if (cnt == SYM_LEN - 20'd1) begin
                        cnt <= '0;
                        if (sym == 7'd99) begin
                            done_r <= 1'b1;
                            sym    <= '0;
                            if (accept) begin
                                irig_r <= 1'b1;
                            end else begin
                                state  <= IDLE;
                                irig_r <= 1'b0;
                                busy_r <= 1'b0;
                            end
                        end else begin
                            sym    <= sym + 7'd1;
                            irig_r <= 1'b1;
                        end
                    end else begin
                        cnt    <= cnt + 20'd1;
                        irig_r <= (cnt + 20'd1) < high_len;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.irig_out   = irig_r;
    assign bus.busy       = busy_r;
    assign bus.bit_idx    = sym;
    assign bus.frame_done = done_r;
endmodule

// File: tb/tb_irig_encoder.sv
// Self-checking bench for irig_encoder: every symbol's pulse width is compared with a
// reference frame derived from the timestamp by BCD arithmetic.
module tb_irig_encoder;
    localparam int CPM = 4;
    localparam int SYM = 10 * CPM;

    logic clk = 1'b0;
    logic rst = 1'b1;

    irig_encoder_if bus();

    irig_encoder #(.CLKS_PER_MS(CPM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_w [100];
    bit exp_fd_first;
    int nxt_s, nxt_m, nxt_h, nxt_d, nxt_y, nxt_sd;

    task automatic drive_ts(input int s, m, h, d, y, sd);
        bus.ts_second  = 6'(s);
        bus.ts_minute  = 6'(m);
        bus.ts_hour    = 5'(h);
        bus.ts_day     = 9'(d);
        bus.ts_year    = 7'(y);
        bus.ts_sec_day = 17'(sd);
    endtask

    task automatic put_digit(input int base, input int val, input int n);
        for (int j = 0; j < n; j++)
            exp_w[base + j] = ((val >> j) & 1) ? 5 : 2;
    endtask

    // Reference frame in milliseconds of high time per symbol.
    task automatic model(input int s, m, h, d, y, sd);
        for (int i = 0; i < 100; i++)
            exp_w[i] = (i == 0 || i % 10 == 9) ? 8 : 2;
        put_digit(1,  s % 10, 4);
        put_digit(6,  (s / 10) % 10, 3);
        put_digit(10, m % 10, 4);
        put_digit(15, (m / 10) % 10, 3);
        put_digit(20, h % 10, 4);
        put_digit(25, (h / 10) % 10, 2);
        put_digit(30, d % 10, 4);
        put_digit(35, (d / 10) % 10, 4);
        put_digit(40, d / 100, 2);
        put_digit(50, y % 10, 4);
        put_digit(55, (y / 10) % 10, 4);
        for (int j = 0; j < 17; j++)
            exp_w[(j < 9) ? 80 + j : 81 + j] = ((sd >> j) & 1) ? 5 : 2;
    endtask

    task automatic random_next();
        nxt_s  = int'($urandom_range(59, 0));
        nxt_m  = int'($urandom_range(59, 0));
        nxt_h  = int'($urandom_range(23, 0));
        nxt_d  = int'($urandom_range(366, 1));
        nxt_y  = int'($urandom_range(99, 0));
        nxt_sd = int'($urandom_range(86399, 0));
    endtask

    task automatic launch(input int s, m, h, d, y, sd);
        @(negedge clk);
        drive_ts(s, m, h, d, y, sd);
        bus.start = 1'b1;
        model(s, m, h, d, y, sd);
    endtask

    task automatic launch_random();
        random_next();
        launch(nxt_s, nxt_m, nxt_h, nxt_d, nxt_y, nxt_sd);
    endtask

    // Walks one whole frame cycle by cycle; optional hooks inject mid-frame events.
    task automatic run_frame(input int abort_at, input bit mid_start, input bit scramble, input bit b2b);
        int   highs;
        bit   shape_bad;
        bit   busy_bad;
        logic exp_hi;
        for (int s = 0; s < 100; s++) begin
            highs = 0;
            shape_bad = 1'b0;
            busy_bad = 1'b0;
            for (int c = 0; c < SYM; c++) begin
                @(negedge clk);
                bus.start = 1'b0;
                if (abort_at == s && c == 5) begin
                    rst = 1'b1;
                    bus.start = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    bus.start = 1'b0;
                    total++;
                    if (bus.irig_out !== 1'b0 || bus.busy !== 1'b0 || bus.bit_idx !== 7'd0 || bus.frame_done !== 1'b0) begin
                        bad++;
                        $display("[TB] FAIL abort_outputs: irig=%b busy=%b bit_idx=%0d done=%b, required 0 0 0 0",
                                 bus.irig_out, bus.busy, bus.bit_idx, bus.frame_done);
                    end
                    @(negedge clk);
                    total++;
                    if (bus.busy !== 1'b0 || bus.irig_out !== 1'b0) begin
                        bad++;
                        $display("[TB] FAIL start_with_rst: busy=%b irig=%b, required 0 0", bus.busy, bus.irig_out);
                    end
                    return;
                end
                if (s == 0 && c == 0) begin
                    total++;
                    if (bus.frame_done !== exp_fd_first) begin
                        bad++;
                        $display("[TB] FAIL frame_done_at_start: got %b, required %b", bus.frame_done, exp_fd_first);
                    end
                end
                if (s == 0 && c == 1) begin
                    total++;
                    if (bus.frame_done !== 1'b0) begin
                        bad++;
                        $display("[TB] FAIL frame_done_width: got %b, required 0", bus.frame_done);
                    end
                end
                if (c == 0) begin
                    total++;
                    if (bus.bit_idx !== 7'(s)) begin
                        bad++;
                        $display("[TB] FAIL bit_idx: got %0d, required %0d", bus.bit_idx, s);
                    end
                end
                exp_hi = (c < exp_w[s] * CPM);
                if (bus.irig_out !== exp_hi) shape_bad = 1'b1;
                if (bus.irig_out === 1'b1) highs++;
                if (bus.busy !== 1'b1) busy_bad = 1'b1;
                if (scramble && s == 20 && c == 0) begin
                    random_next();
                    drive_ts(nxt_s, nxt_m, nxt_h, nxt_d, nxt_y, nxt_sd);
                end
                if (mid_start && s == 50 && c == 10) begin
                    random_next();
                    drive_ts(nxt_s, nxt_m, nxt_h, nxt_d, nxt_y, nxt_sd);
                    bus.start = 1'b1;
                end
                if (b2b && s == 99 && c == SYM - 1) begin
                    random_next();
                    drive_ts(nxt_s, nxt_m, nxt_h, nxt_d, nxt_y, nxt_sd);
                    bus.start = 1'b1;
                end
            end
            total++;
            if (shape_bad || highs != exp_w[s] * CPM) begin
                bad++;
                $display("[TB] FAIL pulse_sym%0d: high cycles %0d (shape_bad=%b), required %0d", s, highs, shape_bad, exp_w[s] * CPM);
            end
            total++;
            if (busy_bad) begin
                bad++;
                $display("[TB] FAIL busy_sym%0d: busy dropped, required 1", s);
            end
        end
    endtask

    task automatic check_idle_after();
        @(negedge clk);
        bus.start = 1'b0;
        total++;
        if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0 || bus.irig_out !== 1'b0 || bus.bit_idx !== 7'd0) begin
            bad++;
            $display("[TB] FAIL frame_end: done=%b busy=%b irig=%b bit_idx=%0d, required 1 0 0 0",
                     bus.frame_done, bus.busy, bus.irig_out, bus.bit_idx);
        end
        @(negedge clk);
        total++;
        if (bus.frame_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL frame_done_width: got %b, required 0", bus.frame_done);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        drive_ts(0, 0, 0, 1, 0, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        total++;
        if (bus.irig_out !== 1'b0 || bus.busy !== 1'b0 || bus.bit_idx !== 7'd0 || bus.frame_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_state: irig=%b busy=%b bit_idx=%0d done=%b, required 0 0 0 0",
                     bus.irig_out, bus.busy, bus.bit_idx, bus.frame_done);
        end
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_after_reset: busy=%b, required 0", bus.busy);
        end
    endtask

    task automatic test_zero_frame();
        exp_fd_first = 1'b0;
        launch(0, 0, 0, 1, 0, 0);
        run_frame(-1, 1'b0, 1'b0, 1'b0);
        check_idle_after();
    endtask

    task automatic test_max_frame();
        exp_fd_first = 1'b0;
        launch(59, 59, 23, 366, 99, 86399);
        run_frame(-1, 1'b0, 1'b0, 1'b0);
        check_idle_after();
    endtask

    task automatic test_ignore_midframe();
        exp_fd_first = 1'b0;
        launch_random();
        run_frame(-1, 1'b1, 1'b1, 1'b0);
        check_idle_after();
    endtask

    task automatic test_back_to_back();
        exp_fd_first = 1'b0;
        launch_random();
        run_frame(-1, 1'b0, 1'b0, 1'b1);
        model(nxt_s, nxt_m, nxt_h, nxt_d, nxt_y, nxt_sd);
        exp_fd_first = 1'b1;
        run_frame(-1, 1'b0, 1'b0, 1'b0);
        check_idle_after();
    endtask

    task automatic test_abort();
        exp_fd_first = 1'b0;
        launch_random();
        run_frame(37, 1'b0, 1'b0, 1'b0);
        launch_random();
        run_frame(-1, 1'b0, 1'b0, 1'b0);
        check_idle_after();
    endtask

    task automatic test_random();
        for (int k = 0; k < 2; k++) begin
            exp_fd_first = 1'b0;
            launch_random();
            run_frame(-1, 1'b0, 1'b0, 1'b0);
            check_idle_after();
        end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_max_frame();
        test_ignore_midframe();
        test_back_to_back();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
